// File: rtl/alu_exec_if.sv
// Request/response bundle between EX-stage issue logic and alu_exec_unit.
interface alu_exec_if #(
   parameter int unsigned XLEN = 32
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [9:0]      funct;
   logic [1:0]      alu_op;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic [2:0]      ctrl;
   logic            illegal;

   modport master (
      output flush, in_valid, funct, alu_op, op_a, op_b, out_ready,
      input  in_ready, out_valid, result, ctrl, illegal
   );

   modport slave (
      input  flush, in_valid, funct, alu_op, op_a, op_b, out_ready,
      output in_ready, out_valid, result, ctrl, illegal
   );
endinterface

// File: rtl/alu_exec_unit.sv
// EX-stage execution unit: decodes funct/alu_op, executes single-cycle ALU ops and an
// iterative multiplier, and holds a registered result behind a valid/ready handshake.
module alu_exec_unit #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned MUL_UNROLL = 4
) (
   input logic       clk,
   input logic       rst,
   alu_exec_if.slave bus
);
   localparam int unsigned Steps = XLEN / MUL_UNROLL;
   localparam int unsigned ShW   = $clog2(XLEN);
   localparam int unsigned CntW  = $clog2(Steps + 1);

   typedef enum logic [2:0] {
      CtrlIll = 3'd0,
      CtrlAdd = 3'd1,
      CtrlSub = 3'd2,
      CtrlMul = 3'd3,
      CtrlAnd = 3'd4,
      CtrlXor = 3'd5,
      CtrlSll = 3'd6,
      CtrlSra = 3'd7
   } ctrl_e;

   typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0] mcand_q, mcand_d;
   logic [XLEN-1:0] mplier_q, mplier_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      ctrl_q, ctrl_d;
   logic            illegal_q, illegal_d;

   ctrl_e           dec_ctrl;
   logic [6:0]      funct7;
   logic [2:0]      funct3;
   logic [ShW-1:0]  shamt;
   logic [XLEN-1:0] alu_res;
   logic [XLEN-1:0] partial;
   logic            in_ready;
   logic            accept;

   assign funct7 = bus.funct[9:3];
   assign funct3 = bus.funct[2:0];
   assign shamt  = bus.op_b[ShW-1:0];

   always_comb begin
      dec_ctrl = CtrlIll;
      case (bus.alu_op)
         2'b00: begin
            if (funct7 == 7'b0000000) begin
               case (funct3)
                  3'b000:  dec_ctrl = CtrlAdd;
                  3'b001:  dec_ctrl = CtrlSll;
                  3'b100:  dec_ctrl = CtrlXor;
                  3'b111:  dec_ctrl = CtrlAnd;
                  default: dec_ctrl = CtrlIll;
               endcase
            end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
               dec_ctrl = CtrlSub;
            end else if (funct3 == 3'b000 && funct7 == 7'b0000001) begin
               dec_ctrl = CtrlMul;
            end
         end
         2'b10: begin
            case (funct3)
               3'b000, 3'b010: dec_ctrl = CtrlAdd;
               3'b101:         dec_ctrl = CtrlSra;
               default:        dec_ctrl = CtrlIll;
            endcase
         end
         default: dec_ctrl = CtrlIll;
      endcase
   end

   // Illegal encodings fall through to zero so no stale value is ever presented.
   always_comb begin
      alu_res = '0;
      case (dec_ctrl)
         CtrlAdd: alu_res = bus.op_a + bus.op_b;
         CtrlSub: alu_res = bus.op_a - bus.op_b;
         CtrlAnd: alu_res = bus.op_a & bus.op_b;
         CtrlXor: alu_res = bus.op_a ^ bus.op_b;
         CtrlSll: alu_res = bus.op_a << shamt;
         CtrlSra: alu_res = XLEN'($signed(bus.op_a) >>> shamt);
         default: alu_res = '0;
      endcase
   end

   // mcand_q carries op_a<<k and mplier_q carries op_b>>k for the current step k.
   assign partial = mcand_q * XLEN'(mplier_q[MUL_UNROLL-1:0]);

   assign in_ready = (state_q == StIdle) ||
                     (state_q == StDone && bus.out_ready && !bus.flush);
   assign accept   = bus.in_valid && in_ready && !bus.flush;

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      ctrl_d    = ctrl_q;
      illegal_d = illegal_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      if (bus.flush) begin
         state_d = StIdle;
         acc_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            StMul: begin
               acc_d    = acc_q + partial;
               mcand_d  = mcand_q << MUL_UNROLL;
               mplier_d = mplier_q >> MUL_UNROLL;
               cnt_d    = cnt_q - CntW'(1);
               if (cnt_q == CntW'(1)) begin
                  state_d  = StDone;
                  result_d = acc_q + partial;
               end
            end
            StDone: begin
               if (bus.out_ready) state_d = StIdle;
            end
            default: ;
         endcase
         if (accept) begin
            ctrl_d    = dec_ctrl;
            illegal_d = (dec_ctrl == CtrlIll);
            if (dec_ctrl == CtrlMul) begin
               state_d  = StMul;
               acc_d    = '0;
               cnt_d    = CntW'(Steps);
               mcand_d  = bus.op_a;
               mplier_d = bus.op_b;
            end else begin
               state_d  = StDone;
               result_d = alu_res;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         result_q  <= '0;
         ctrl_q    <= '0;
         illegal_q <= 1'b0;
         acc_q     <= '0;
         cnt_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         ctrl_q    <= ctrl_d;
         illegal_q <= illegal_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (state_q == StDone);
   assign bus.result    = result_q;
   assign bus.ctrl      = ctrl_q;
   assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit: a 32-bit/unroll-4 main instance plus
// unroll-1, unroll-8 and 64-bit instances driven in lockstep for flush and MUL checks.
module tb_alu_exec_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [9:0]  funct = '0;
   logic [1:0]  alu_op = '0;
   logic [63:0] op_a = '0;
   logic [63:0] op_b = '0;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   localparam logic [9:0] FMul = 10'b0000001_000;

   always #5 clk = ~clk;

   alu_exec_if #(.XLEN(32)) if_main ();
   alu_exec_if #(.XLEN(32)) if_u1 ();
   alu_exec_if #(.XLEN(32)) if_u8 ();
   alu_exec_if #(.XLEN(64)) if_x64 ();

   assign {if_main.flush, if_main.in_valid, if_main.out_ready} = {flush, in_valid, out_ready};
   assign {if_main.funct, if_main.alu_op} = {funct, alu_op};
   assign {if_main.op_a, if_main.op_b} = {op_a[31:0], op_b[31:0]};
   assign {if_u1.flush, if_u1.in_valid, if_u1.out_ready} = {flush, in_valid, out_ready};
   assign {if_u1.funct, if_u1.alu_op} = {funct, alu_op};
   assign {if_u1.op_a, if_u1.op_b} = {op_a[31:0], op_b[31:0]};
   assign {if_u8.flush, if_u8.in_valid, if_u8.out_ready} = {flush, in_valid, out_ready};
   assign {if_u8.funct, if_u8.alu_op} = {funct, alu_op};
   assign {if_u8.op_a, if_u8.op_b} = {op_a[31:0], op_b[31:0]};
   assign {if_x64.flush, if_x64.in_valid, if_x64.out_ready} = {flush, in_valid, out_ready};
   assign {if_x64.funct, if_x64.alu_op} = {funct, alu_op};
   assign {if_x64.op_a, if_x64.op_b} = {op_a, op_b};

   alu_exec_unit #(.XLEN(32), .MUL_UNROLL(4)) u_main (.clk(clk), .rst(rst), .bus(if_main));
   alu_exec_unit #(.XLEN(32), .MUL_UNROLL(1)) u_u1   (.clk(clk), .rst(rst), .bus(if_u1));
   alu_exec_unit #(.XLEN(32), .MUL_UNROLL(8)) u_u8   (.clk(clk), .rst(rst), .bus(if_u8));
   alu_exec_unit #(.XLEN(64), .MUL_UNROLL(4)) u_x64  (.clk(clk), .rst(rst), .bus(if_x64));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [1:0] op, input logic [9:0] f,
                        input logic [63:0] a, input logic [63:0] b);
      alu_op   = op;
      funct    = f;
      op_a     = a;
      op_b     = b;
      in_valid = 1'b1;
   endtask

   // Single-cycle op on the main instance: issue from idle, hold, then drain.
   task automatic run_op(input string tag, input logic [1:0] op, input logic [9:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic [2:0] ctl, input logic ill);
      offer(op, f, {32'h0, a}, {32'h0, b});
      step();
      in_valid = 1'b0;
      check({tag, ".valid"}, if_main.out_valid, 1);
      check({tag, ".result"}, if_main.result, res);
      check({tag, ".ctrl"}, if_main.ctrl, ctl);
      check({tag, ".illegal"}, if_main.illegal, ill);
      step();
      check({tag, ".hold"}, if_main.result, res);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, ".drain"}, if_main.out_valid, 0);
   endtask

   task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res);
      int n;
      logic busy_ok;
      offer(2'b00, FMul, {32'h0, a}, {32'h0, b});
      step();
      in_valid = 1'b0;
      n = 0;
      busy_ok = 1'b1;
      while (!if_main.out_valid && n < 40) begin
         if (if_main.in_ready) busy_ok = 1'b0;
         n++;
         step();
      end
      check({tag, ".busy_cycles"}, n, 8);
      check({tag, ".ready_low"}, busy_ok, 1);
      check({tag, ".result"}, if_main.result, res);
      check({tag, ".ctrl"}, if_main.ctrl, 3);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      logic seen;
      step();
      check("rst.valid", if_main.out_valid, 0);
      check("rst.ready", if_main.in_ready, 1);
      check("rst.ctrl", if_main.ctrl, 0);
      check("rst.result", if_main.result, 0);
      rst = 1'b0;
      step();

      run_op("sub",     2'b00, 10'b0100000_000, 32'd5,         32'd7,         32'hFFFF_FFFE, 3'd2, 1'b0);
      run_op("srai",    2'b10, 10'b0000000_101, 32'h8000_0000, 32'd4,         32'hF800_0000, 3'd7, 1'b0);
      run_op("sra_pos", 2'b10, 10'b0100000_101, 32'h7FFF_FFF0, 32'h23,        32'h0FFF_FFFE, 3'd7, 1'b0);
      run_op("add",     2'b00, 10'b0000000_000, 32'hFFFF_FFFF, 32'd1,         32'h0,         3'd1, 1'b0);
      run_op("xor",     2'b00, 10'b0000000_100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 3'd5, 1'b0);
      run_op("and",     2'b00, 10'b0000000_111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 3'd4, 1'b0);
      run_op("sll",     2'b00, 10'b0000000_001, 32'd1,         32'h23,        32'd8,         3'd6, 1'b0);
      run_op("addi",    2'b10, 10'b0000000_010, 32'd10,        32'hFFFF_FFFF, 32'd9,         3'd1, 1'b0);
      run_op("op01",    2'b01, 10'b0000000_000, 32'd1,         32'd1,         32'h0,         3'd0, 1'b1);
      run_op("op11",    2'b11, 10'b0000000_000, 32'd1,         32'd1,         32'h0,         3'd0, 1'b1);
      run_op("r_f3_010", 2'b00, 10'b0000000_010, 32'd3,        32'd3,         32'h0,         3'd0, 1'b1);
      run_op("i_f3_001", 2'b10, 10'b0000000_001, 32'd3,        32'd3,         32'h0,         3'd0, 1'b1);

      run_mul("mul_neg", 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
      run_mul("mul_sq",  32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001);

      // Illegal result released with a new ADD accepted in the same cycle.
      offer(2'b00, 10'b0000001_111, 64'd9, 64'd9);
      step();
      in_valid = 1'b0;
      check("b2b.ill_flag", if_main.illegal, 1);
      check("b2b.ill_ctrl", if_main.ctrl, 0);
      check("b2b.ill_result", if_main.result, 0);
      offer(2'b00, 10'b0000000_000, 64'd3, 64'd4);
      out_ready = 1'b1;
      #1;
      check("b2b.ready", if_main.in_ready, 1);
      step();
      in_valid = 1'b0;
      check("b2b.valid", if_main.out_valid, 1);
      check("b2b.result", if_main.result, 7);
      check("b2b.ctrl", if_main.ctrl, 1);
      check("b2b.illegal", if_main.illegal, 0);
      step();
      out_ready = 1'b0;
      check("b2b.drain", if_main.out_valid, 0);

      // Flush with an op offered in idle must not accept it.
      offer(2'b00, 10'b0000000_000, 64'd1, 64'd1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      check("flush_idle.valid", if_main.out_valid, 0);

      // Asynchronous reset in the middle of a multiply.
      offer(2'b00, FMul, 64'hFFFF_FFFF, 64'd3);
      step();
      in_valid = 1'b0;
      step();
      rst = 1'b1;
      #2;
      check("rst_mul.valid", if_main.out_valid, 0);
      check("rst_mul.ready", if_main.in_ready, 1);
      check("rst_mul.ctrl", if_main.ctrl, 0);
      check("rst_mul.result", if_main.result, 0);
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (if_main.out_valid) seen = 1'b1;
      end
      check("rst_mul.no_partial", seen, 0);

      // Flush at MUL step 4 on every configuration.
      flush = 1'b1;
      step();
      flush = 1'b0;
      offer(2'b00, FMul, 64'd3, 64'd5);
      step();
      in_valid = 1'b0;
      repeat (3) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_mul.main_ready", if_main.in_ready, 1);
      check("flush_mul.u1_ready", if_u1.in_ready, 1);
      check("flush_mul.u8_ready", if_u8.in_ready, 1);
      check("flush_mul.x64_ready", if_x64.in_ready, 1);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (if_main.out_valid || if_u1.out_valid || if_u8.out_valid || if_x64.out_valid)
            seen = 1'b1;
         step();
      end
      check("flush_mul.no_valid", seen, 0);
      offer(2'b00, 10'b0000000_000, 64'd1, 64'd1);
      step();
      in_valid = 1'b0;
      check("post_flush.main", if_main.result, 2);
      check("post_flush.u1", if_u1.result, 2);
      check("post_flush.u8", if_u8.result, 2);
      check("post_flush.x64", if_x64.result, 2);
      check("post_flush.valid", if_x64.out_valid & if_u1.out_valid & if_u8.out_valid, 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // Full multiply on every configuration exercising the top operand bits.
      offer(2'b00, FMul, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_8000_0001);
      step();
      in_valid = 1'b0;
      repeat (40) step();
      check("mul_all.main", if_main.result, 32'h7FFF_FFFF);
      check("mul_all.u1", if_u1.result, 32'h7FFF_FFFF);
      check("mul_all.u8", if_u8.result, 32'h7FFF_FFFF);
      check("mul_all.x64", if_x64.result, 64'hFFFF_FFFF_7FFF_FFFF);
      check("mul_all.valid",
            if_main.out_valid & if_u1.out_valid & if_u8.out_valid & if_x64.out_valid, 1);
      check("mul_all.x64_ctrl", if_x64.ctrl, 3);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
